// File: rtl/timer_ctrl.sv
// Prescaled up-counter timer with start/pause/abort command handling,
// one-shot or periodic reload, and a sticky terminal-count interrupt.
module timer_ctrl #(
  parameter int WIDTH     = 8,
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     period,
  input  logic [PSC_WIDTH-1:0] prescale,
  input  logic                 auto_reload,
  input  logic                 irq_clr,
  output logic [WIDTH-1:0]     count,
  output logic                 tc,
  output logic                 irq,
  output logic                 busy,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     period_q, period_d;
  logic [PSC_WIDTH-1:0] psc_q, psc_d;
  logic [PSC_WIDTH-1:0] prescale_q, prescale_d;
  logic                 reload_q, reload_d;
  logic                 irq_q, irq_d;
  logic                 irq_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      psc_q      <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      reload_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      psc_q      <= psc_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      reload_q   <= reload_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    psc_d      = psc_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    reload_d   = reload_q;
    irq_set    = 1'b0;

    // abort > pause > start; a losing command is dropped, not deferred
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
      psc_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          count_d = '0;
          psc_d   = '0;
          if (!pause && start) begin
            period_d   = period;
            prescale_d = prescale;
            reload_d   = auto_reload;
            state_d    = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (psc_q != prescale_q) begin
            psc_d = psc_q + 1'b1;
          end else begin
            psc_d = '0;
            if (count_q != period_q) begin
              count_d = count_q + 1'b1;
            end else begin
              count_d = '0;
              irq_set = 1'b1;
              if (!reload_q) state_d = DONE;
            end
          end
        end
        PAUSE: begin
          if (!pause && start) state_d = RUN;
        end
      endcase
    end

    // a terminal step wins over a simultaneous clear
    irq_d = (irq_q & ~irq_clr) | irq_set;
  end

  assign count = count_q;
  assign irq   = irq_q;
  assign state = state_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign tc    = (state_q == RUN) && (count_q == period_q) && (psc_q == prescale_q);

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus randomized commands, checked
// against a tick-accumulator model of the timer.
module tb_timer_ctrl;
  localparam int W  = 8;
  localparam int PW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic          auto_reload = 1'b0, irq_clr = 1'b0;
  logic [W-1:0]  period = '0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  count;
  logic          tc, irq, busy;
  logic [1:0]    state;

  int n_run  = 0;
  int n_fail = 0;

  // Model: state code, elapsed prescaled clocks in the current period, latched settings
  int m_st = 0, m_ticks = 0, m_P = 0, m_S = 0, m_irq = 0;
  bit m_R = 1'b0;

  timer_ctrl #(.WIDTH(W), .PSC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .period(period), .prescale(prescale), .auto_reload(auto_reload),
    .irq_clr(irq_clr), .count(count), .tc(tc), .irq(irq), .busy(busy),
    .state(state)
  );

  task automatic model_update();
    int  old;
    bit  set;
    set = 1'b0;
    old = m_st;
    if (rst) begin
      m_st = 0; m_ticks = 0; m_P = 0; m_S = 0; m_R = 1'b0; m_irq = 0;
      return;
    end
    if (abort) begin
      m_st = 0; m_ticks = 0;
    end else if (pause) begin
      if (old == 1) m_st = 2;
    end else if (start && (old == 0 || old == 3)) begin
      m_P = int'(period); m_S = int'(prescale); m_R = auto_reload;
      m_ticks = 0; m_st = 1;
    end else if (start && old == 2) begin
      m_st = 1;
    end else if (old == 1) begin
      m_ticks++;
      if (m_ticks == (m_P + 1) * (m_S + 1)) begin
        m_ticks = 0;
        set = 1'b1;
        if (!m_R) m_st = 3;
      end
    end
    if (irq_clr) m_irq = 0;
    if (set) m_irq = 1;
  endtask

  // {state, count, tc, irq, busy}
  function automatic logic [12:0] expv();
    int         c;
    logic       b, t;
    logic [1:0] s2;
    logic [7:0] c8;
    b  = (m_st == 1) || (m_st == 2);
    c  = b ? m_ticks / (m_S + 1) : 0;
    t  = (m_st == 1) && (m_ticks == (m_P + 1) * (m_S + 1) - 1);
    s2 = m_st[1:0];
    c8 = c[7:0];
    return {s2, c8, t, (m_irq != 0), b};
  endfunction

  function automatic logic [12:0] dutv();
    return {state, count, tc, irq, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; irq_clr = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic kick(input logic [W-1:0] p, input logic [PW-1:0] s, input logic ar);
    period = p; prescale = s; auto_reload = ar;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if ({state, count, busy, irq, tc} !== {2'b00, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: got st=%0d cnt=%0h busy=%0b irq=%0b tc=%0b, want 0/00/0/0/0",
               state, count, busy, irq, tc);
    end
  endtask

  task automatic test_periodic_full();
    do_reset();
    kick(8'hFF, 8'h00, 1'b1);
    repeat (255) tick();
    n_run++;
    if ({count, tc} !== {8'hFF, 1'b1}) begin
      n_fail++; $display("FAIL full_tc: got cnt=%0h tc=%0b, want FF/1", count, tc);
    end
    tick();
    n_run++;
    if ({count, tc, irq, state} !== {8'h00, 1'b0, 1'b1, 2'b01}) begin
      n_fail++;
      $display("FAIL full_wrap: got cnt=%0h tc=%0b irq=%0b st=%0d, want 00/0/1/1",
               count, tc, irq, state);
    end
    repeat (10) tick();
    n_run++;
    if (count !== 8'h0A) begin
      n_fail++; $display("FAIL full_after10: got cnt=%0h, want 0A", count);
    end
    n_run++;
    if (dutv() !== expv()) begin
      n_fail++; $display("FAIL full_model: got %h, want %h", dutv(), expv());
    end
  endtask

  task automatic test_oneshot_prescale();
    do_reset();
    kick(8'd3, 8'd2, 1'b0);
    repeat (3) tick();
    n_run++;
    if (count !== 8'd1) begin
      n_fail++; $display("FAIL oneshot_first: got cnt=%0d, want 1", count);
    end
    repeat (9) tick();
    n_run++;
    if ({state, busy, count, irq} !== {2'b11, 1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL oneshot_done: got st=%0d busy=%0b cnt=%0d irq=%0b, want 3/0/0/1",
               state, busy, count, irq);
    end
    repeat (4) tick();
    n_run++;
    if (dutv() !== expv()) begin
      n_fail++; $display("FAIL oneshot_hold: got %h, want %h", dutv(), expv());
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    kick(8'd20, 8'd1, 1'b1);
    repeat (10) tick();
    n_run++;
    if (count !== 8'd5) begin
      n_fail++; $display("FAIL pause_pre: got cnt=%0d, want 5", count);
    end
    pause = 1'b1;
    period = 8'd2; prescale = 8'd0;
    repeat (20) tick();
    pause = 1'b0;
    n_run++;
    if ({count, state} !== {8'd5, 2'b10}) begin
      n_fail++; $display("FAIL pause_hold: got cnt=%0d st=%0d, want 5/2", count, state);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_run++;
    if (state !== 2'b01) begin
      n_fail++; $display("FAIL resume_state: got st=%0d, want 1", state);
    end
    repeat (2) tick();
    n_run++;
    if (count !== 8'd6) begin
      n_fail++; $display("FAIL resume_count: got cnt=%0d, want 6", count);
    end
  endtask

  task automatic test_irq_race_abort();
    do_reset();
    kick(8'd3, 8'd0, 1'b1);
    repeat (3) tick();
    n_run++;
    if (tc !== 1'b1) begin
      n_fail++; $display("FAIL race_tc: got tc=%0b, want 1", tc);
    end
    irq_clr = 1'b1;
    tick();
    n_run++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL race_set_wins: got irq=%0b, want 1", irq);
    end
    tick();
    irq_clr = 1'b0;
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL race_clear: got irq=%0b, want 0", irq);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    kick(8'd20, 8'd0, 1'b1);
    repeat (7) tick();
    abort = 1'b1; start = 1'b1; pause = 1'b1;
    tick();
    clear_inputs();
    n_run++;
    if ({state, count, irq} !== {2'b00, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL abort: got st=%0d cnt=%0d irq=%0b, want 0/0/0", state, count, irq);
    end
  endtask

  task automatic test_period_zero();
    do_reset();
    kick(8'd0, 8'd0, 1'b1);
    n_run++;
    if ({count, tc, irq} !== {8'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL p0_start: got cnt=%0d tc=%0b irq=%0b, want 0/1/0", count, tc, irq);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_run++;
      if ({count, tc, irq, state} !== {8'd0, 1'b1, 1'b1, 2'b01}) begin
        n_fail++;
        $display("FAIL p0_cycle%0d: got cnt=%0d tc=%0b irq=%0b st=%0d, want 0/1/1/1",
                 i, count, tc, irq, state);
      end
    end
  endtask

  task automatic test_reset_override();
    do_reset();
    kick(8'd9, 8'd1, 1'b1);
    repeat (5) tick();
    rst = 1'b1; start = 1'b1; pause = 1'b1; irq_clr = 1'b1;
    tick();
    clear_inputs();
    n_run++;
    if ({state, count, busy, irq, tc} !== {2'b00, 8'd0, 3'b000}) begin
      n_fail++; $display("FAIL rst_run: got st=%0d cnt=%0d busy=%0b, want 0/0/0", state, count, busy);
    end
    kick(8'd9, 8'd0, 1'b1);
    pause = 1'b1;
    repeat (3) tick();
    pause = 1'b0;
    rst = 1'b1; start = 1'b1;
    tick();
    clear_inputs();
    n_run++;
    if ({state, count, busy} !== {2'b00, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL rst_pause: got st=%0d cnt=%0d busy=%0b, want 0/0/0", state, count, busy);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r           = $urandom_range(0, 99);
      abort       = (r < 2);
      pause       = (r >= 2 && r < 6);
      start       = (r >= 6 && r < 16);
      irq_clr     = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      period      = W'($urandom_range(0, 7));
      prescale    = PW'($urandom_range(0, 3));
      auto_reload = $urandom_range(0, 1) != 0;
      tick();
      n_run++;
      if (dutv() !== expv()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got {st,cnt,tc,irq,busy}=%h, want %h", i, dutv(), expv());
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_periodic_full();
    test_oneshot_prescale();
    test_pause_resume();
    test_irq_race_abort();
    test_period_zero();
    test_reset_override();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
